// File: rtl/conversor_pkg.sv
// Shared types and helpers for the parametrised serial-to-parallel converter.
package conversor_pkg;

  localparam int unsigned DEFAULT_WIDTH = 8;

  typedef enum logic {
    S_SHIFT  = 1'b0,
    S_PARITY = 1'b1
  } state_e;

  // Number of bits needed to hold values 0..v-1 (minimum 1 for v>1).
  function automatic int unsigned clog2(input int unsigned v);
    int unsigned r;
    r = 0;
    for (int unsigned i = 0; i < 32; i++) begin
      if ((64'd1 << i) < 64'(v)) r = i + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/shift_reg_param.sv
// Serial-in shift register with selectable entry end; preset loads all ones.
module shift_reg_param #(
  parameter int unsigned WIDTH     = 8,
  parameter bit          MSB_FIRST = 1'b1
) (
  input  logic             clk,
  input  logic             clear,
  input  logic             preset,
  input  logic             en,
  input  logic             d,
  output logic [WIDTH-1:0] sr
);

  logic [WIDTH-1:0] sr_q, sr_d;

  always_comb begin
    sr_d = sr_q;
    if (preset) begin
      sr_d = '1;
    end else if (en) begin
      sr_d = MSB_FIRST ? {sr_q[WIDTH-2:0], d} : {d, sr_q[WIDTH-1:1]};
    end
  end

  always_ff @(posedge clk or posedge clear) begin
    if (clear) sr_q <= '0;
    else       sr_q <= sr_d;
  end

  assign sr = sr_q;

endmodule

// File: rtl/conversor_serie_paralelo_param.sv
// Serial-to-parallel converter with valid/ack holding register and sticky overrun.
// Optional even-parity bit after each word when PARITY_EN is defined.
module conversor_serie_paralelo_param
  import conversor_pkg::*;
#(
  parameter int unsigned WIDTH     = DEFAULT_WIDTH,
  parameter bit          MSB_FIRST = 1'b1
) (
  input  logic                         clk,
  input  logic                         clear,
  input  logic                         preset,
  input  logic                         d,
  input  logic                         d_en,
  output logic [WIDTH-1:0]             q,
  output logic                         q_valid,
  input  logic                         q_ack,
  output logic                         busy,
  output logic                         overrun,
  output logic [clog2(WIDTH+1)-1:0]    bit_cnt
`ifdef PARITY_EN
  ,
  output logic                         parity_err
`endif
);

  localparam int unsigned     CNT_W    = clog2(WIDTH + 1);
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH - 1);

  logic [WIDTH-1:0] sr, word_c, q_q, q_d;
  logic [CNT_W-1:0] cnt_q, cnt_d, wrap_c;
  logic             q_valid_q, q_valid_d, overrun_q, overrun_d, busy_q, busy_d;
  logic             shift_en_c, complete_c;

  shift_reg_param #(.WIDTH(WIDTH), .MSB_FIRST(MSB_FIRST)) u_sr (
    .clk    (clk),
    .clear  (clear),
    .preset (preset),
    .en     (shift_en_c),
    .d      (d),
    .sr     (sr)
  );

`ifdef PARITY_EN
  state_e state_q, state_d;
  logic   perr_q, perr_d;

  always_ff @(posedge clk or posedge clear) begin
    if (clear) state_q <= S_SHIFT;
    else       state_q <= state_d;
  end

  // Data bits shift in S_SHIFT; the extra bit in S_PARITY completes the word.
  always_comb begin
    state_d    = state_q;
    shift_en_c = 1'b0;
    complete_c = 1'b0;
    word_c     = sr;
    wrap_c     = CNT_W'(WIDTH);
    case (state_q)
      S_SHIFT: begin
        shift_en_c = d_en & ~preset;
        if (shift_en_c && (cnt_q == LAST_CNT)) state_d = S_PARITY;
      end
      S_PARITY: begin
        complete_c = d_en & ~preset;
        if (preset || d_en) state_d = S_SHIFT;
      end
      default: state_d = S_SHIFT;
    endcase
  end

  always_comb begin
    perr_d = perr_q;
    if (complete_c)                perr_d = ^{sr, d};
    else if (q_valid_q && q_ack)   perr_d = 1'b0;
  end

  always_ff @(posedge clk or posedge clear) begin
    if (clear) perr_q <= 1'b0;
    else       perr_q <= perr_d;
  end

  assign parity_err = perr_q;
`else
  logic [WIDTH-1:0] shifted_c;

  // Completion captures the word including the bit arriving on this edge.
  assign shifted_c  = MSB_FIRST ? {sr[WIDTH-2:0], d} : {d, sr[WIDTH-1:1]};
  assign shift_en_c = d_en & ~preset;
  assign complete_c = shift_en_c & (cnt_q == LAST_CNT);
  assign word_c     = shifted_c;
  assign wrap_c     = '0;
`endif

  always_comb begin
    cnt_d     = cnt_q;
    q_d       = q_q;
    q_valid_d = q_valid_q;
    overrun_d = overrun_q;
    if (preset) begin
      cnt_d = '0;
    end else if (shift_en_c) begin
      cnt_d = (cnt_q == LAST_CNT) ? wrap_c : cnt_q + CNT_W'(1);
    end else if (complete_c) begin
      cnt_d = '0;
    end
    if (complete_c) begin
      q_d       = word_c;
      q_valid_d = 1'b1;
      if (q_valid_q && !q_ack) overrun_d = 1'b1;
    end else if (q_valid_q && q_ack) begin
      q_valid_d = 1'b0;
    end
    if (preset) overrun_d = 1'b0;
    busy_d = (cnt_d != '0);
  end

  always_ff @(posedge clk or posedge clear) begin
    if (clear) begin
      cnt_q     <= '0;
      q_q       <= '0;
      q_valid_q <= 1'b0;
      overrun_q <= 1'b0;
      busy_q    <= 1'b0;
    end else begin
      cnt_q     <= cnt_d;
      q_q       <= q_d;
      q_valid_q <= q_valid_d;
      overrun_q <= overrun_d;
      busy_q    <= busy_d;
    end
  end

  assign q       = q_q;
  assign q_valid = q_valid_q;
  assign overrun = overrun_q;
  assign busy    = busy_q;
  assign bit_cnt = cnt_q;

endmodule

// File: tb/tb_conversor_serie_paralelo_param.sv
// Bench: MSB-first and LSB-first 8-bit converters (plus a 4-bit parity one with PARITY_EN)
// driven by one shared directed stream and checked every cycle against a word-level model.
module tb_conversor_serie_paralelo_param;

`ifdef PARITY_EN
  localparam int NI = 3;
  localparam int M_W[NI]   = '{8, 8, 4};
  localparam bit M_MSB[NI] = '{1'b1, 1'b0, 1'b1};
  localparam bit M_PAR[NI] = '{1'b0, 1'b0, 1'b1};
`else
  localparam int NI = 2;
  localparam int M_W[NI]   = '{8, 8};
  localparam bit M_MSB[NI] = '{1'b1, 1'b0};
  localparam bit M_PAR[NI] = '{1'b0, 1'b0};
`endif

  logic clk = 1'b0;
  logic clear, preset, d, d_en, q_ack;

  logic [7:0] q_m, q_l;
  logic       v_m, v_l, b_m, b_l, o_m, o_l;
  logic [3:0] c_m, c_l;

  int vectors = 0;
  int miscompares = 0;

  logic [31:0] a_q[NI], a_c[NI];
  logic        a_v[NI], a_b[NI], a_o[NI], a_pe[NI];

  always #5 clk = ~clk;

  conversor_serie_paralelo_param #(.WIDTH(8), .MSB_FIRST(1'b1)) dut_m (
    .clk(clk), .clear(clear), .preset(preset), .d(d), .d_en(d_en),
    .q(q_m), .q_valid(v_m), .q_ack(q_ack), .busy(b_m), .overrun(o_m), .bit_cnt(c_m)
`ifdef PARITY_EN
    , .parity_err(a_pe[0])
`endif
  );

  conversor_serie_paralelo_param #(.WIDTH(8), .MSB_FIRST(1'b0)) dut_l (
    .clk(clk), .clear(clear), .preset(preset), .d(d), .d_en(d_en),
    .q(q_l), .q_valid(v_l), .q_ack(q_ack), .busy(b_l), .overrun(o_l), .bit_cnt(c_l)
`ifdef PARITY_EN
    , .parity_err(a_pe[1])
`endif
  );

  assign a_q[0] = 32'(q_m); assign a_v[0] = v_m; assign a_b[0] = b_m; assign a_o[0] = o_m; assign a_c[0] = 32'(c_m);
  assign a_q[1] = 32'(q_l); assign a_v[1] = v_l; assign a_b[1] = b_l; assign a_o[1] = o_l; assign a_c[1] = 32'(c_l);

`ifdef PARITY_EN
  logic [3:0] q_p;
  logic [2:0] c_p;
  logic       v_p, b_p, o_p;
  conversor_serie_paralelo_param #(.WIDTH(4), .MSB_FIRST(1'b1)) dut_p (
    .clk(clk), .clear(clear), .preset(preset), .d(d), .d_en(d_en),
    .q(q_p), .q_valid(v_p), .q_ack(q_ack), .busy(b_p), .overrun(o_p), .bit_cnt(c_p),
    .parity_err(a_pe[2])
  );
  assign a_q[2] = 32'(q_p); assign a_v[2] = v_p; assign a_b[2] = b_p; assign a_o[2] = o_p; assign a_c[2] = 32'(c_p);
`else
  assign a_pe[0] = 1'b0;
  assign a_pe[1] = 1'b0;
`endif

  // Word-level model: collect accepted bits, assemble the word when enough have arrived.
  int       m_n[NI];
  bit [31:0] m_bits[NI], m_q[NI];
  bit       m_v[NI], m_ov[NI], m_pe[NI];

  task automatic model_step(input int i);
    bit done, pe;
    bit [31:0] w;
    done = 1'b0; pe = 1'b0; w = '0;
    if (preset) begin
      m_n[i] = 0;
      m_ov[i] = 1'b0;
    end else if (d_en) begin
      m_bits[i][m_n[i]] = d;
      m_n[i]++;
      if (m_n[i] == M_W[i] + int'(M_PAR[i])) begin
        done = 1'b1;
        for (int k = 0; k < M_W[i]; k++) begin
          if (M_MSB[i]) w[M_W[i]-1-k] = m_bits[i][k];
          else          w[k]          = m_bits[i][k];
        end
        for (int k = 0; k < m_n[i]; k++) pe ^= m_bits[i][k];
        m_n[i] = 0;
      end
    end
    if (done) begin
      if (m_v[i] && !q_ack) m_ov[i] = 1'b1;
      m_q[i] = w; m_v[i] = 1'b1; m_pe[i] = pe;
    end else if (m_v[i] && q_ack) begin
      m_v[i] = 1'b0; m_pe[i] = 1'b0;
    end
  endtask

  always @(posedge clk or posedge clear) begin
    for (int i = 0; i < NI; i++) begin
      if (clear) begin
        m_n[i] = 0; m_q[i] = '0; m_v[i] = 1'b0; m_ov[i] = 1'b0; m_pe[i] = 1'b0;
      end else begin
        model_step(i);
      end
    end
  end

  task automatic check(input string nm, input int i, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s dut%0d at %0t: got %0h expected %0h", nm, i, $time, act, exp);
    end
  endtask

  // Every-cycle comparison against the model, away from the rising edge.
  always @(negedge clk) begin
    for (int i = 0; i < NI; i++) begin
      check("q",       i, a_q[i],        m_q[i]);
      check("q_valid", i, 32'(a_v[i]),   32'(m_v[i]));
      check("overrun", i, 32'(a_o[i]),   32'(m_ov[i]));
      check("bit_cnt", i, a_c[i],        32'(m_n[i]));
      check("busy",    i, 32'(a_b[i]),   32'(m_n[i] != 0));
      if (M_PAR[i]) check("parity_err", i, 32'(a_pe[i]), 32'(m_pe[i]));
    end
  end

  // One clock of stimulus; returns 1 time unit after the edge that sampled it.
  task automatic cyc(input logic clr, input logic pre, input logic b, input logic en, input logic ack);
    clear = clr; preset = pre; d = b; d_en = en; q_ack = ack;
    @(posedge clk);
    #1;
  endtask

  task automatic send8(input logic [7:0] w, input logic ack_last);
    for (int k = 7; k >= 0; k--) cyc(1'b0, 1'b0, w[k], 1'b1, (k == 0) ? ack_last : 1'b0);
  endtask

  initial begin
    clear = 1'b1; preset = 1'b0; d = 1'b0; d_en = 1'b0; q_ack = 1'b0;
    // Reset held two clocks while data is offered.
    cyc(1'b1, 1'b0, 1'b1, 1'b1, 1'b0);
    cyc(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    check("rst_q",   0, 32'(q_m), 32'h0);
    check("rst_v",   0, 32'(v_m), 32'h0);
    check("rst_ov",  0, 32'(o_m), 32'h0);
    check("rst_cnt", 0, 32'(c_m), 32'h0);
    cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    check("rel_q", 0, 32'(q_m), 32'h0);

    // B2 back-to-back: MSB-first gives B2, LSB-first gives 4D.
    for (int k = 7; k >= 1; k--) cyc(1'b0, 1'b0, (8'hB2 >> k) & 1'b1, 1'b1, 1'b0);
    check("pre_last_v", 0, 32'(v_m), 32'h0);
    cyc(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    check("msb_q", 0, 32'(q_m), 32'hB2);
    check("msb_v", 0, 32'(v_m), 32'h1);
    check("lsb_q", 1, 32'(q_l), 32'h4D);
    cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    check("ack_v", 0, 32'(v_m), 32'h0);
    cyc(1'b0, 1'b0, 1'b1, 1'b0, 1'b1);   // ack with nothing pending

    // Same stream with idle gaps mid-word.
    cyc(1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
    cyc(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    cyc(1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
    cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    check("gap_busy", 0, 32'(b_m), 32'h1);
    check("gap_cnt",  0, 32'(c_m), 32'h3);
    cyc(1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    check("gap_busy2", 1, 32'(b_l), 32'h1);
    cyc(1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
    cyc(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    cyc(1'b0, 1'b0, 1'b0, 0, 1'b0);
    cyc(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    cyc(1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
    cyc(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    check("gap_lsb_q", 1, 32'(q_l), 32'h4D);
    check("gap_msb_q", 0, 32'(q_m), 32'hB2);
    cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);

    // Overrun: two words without ack, then preset (with d_en high) clears it.
    send8(8'hA5, 1'b0);
    check("ovA_ov", 0, 32'(o_m), 32'h0);
    send8(8'h3C, 1'b0);
    check("ov_q",  0, 32'(q_m), 32'h3C);
    check("ov_v",  0, 32'(v_m), 32'h1);
    check("ov_ov", 0, 32'(o_m), 32'h1);
    cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    cyc(1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
    cyc(1'b0, 1'b1, 1'b1, 1'b1, 1'b0);
    check("pre_ov",  0, 32'(o_m), 32'h0);
    check("pre_cnt", 0, 32'(c_m), 32'h0);
    check("pre_q",   0, 32'(q_m), 32'h3C);
    cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);

    // Ack on the same edge a new word completes.
    send8(8'h5A, 1'b0);
    send8(8'hC3, 1'b1);
    check("sim_q",  0, 32'(q_m), 32'hC3);
    check("sim_v",  0, 32'(v_m), 32'h1);
    check("sim_ov", 0, 32'(o_m), 32'h0);
    cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);

    // Reset mid-word discards the partial word.
    for (int k = 0; k < 4; k++) cyc(1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
    cyc(1'b1, 1'b0, 1'b1, 1'b1, 1'b0);
    check("mid_cnt", 0, 32'(c_m), 32'h0);
    send8(8'hB2, 1'b0);
    check("mid_q", 0, 32'(q_m), 32'hB2);
    cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);

`ifdef PARITY_EN
    cyc(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    cyc(1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
    cyc(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    cyc(1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
    cyc(1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
    check("par_wait_v",  2, 32'(v_p), 32'h0);
    check("par_cnt",     2, 32'(c_p), 32'h4);
    cyc(1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
    check("par_q",   2, 32'(q_p),    32'hB);
    check("par_v",   2, 32'(v_p),    32'h1);
    check("par_ok",  2, 32'(a_pe[2]), 32'h0);
    cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    cyc(1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
    cyc(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    cyc(1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
    cyc(1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
    cyc(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    check("par_err", 2, 32'(a_pe[2]), 32'h1);
    cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    check("par_clr", 2, 32'(a_pe[2]), 32'h0);
`endif

    cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
